// File: rtl/axi_sram_if.sv
// AXI burst channel bundle (aw, w, b, ar, r) between an upstream master and the SRAM slave.
interface axi_sram_if;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        arready;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;

    modport slave (
        input  awaddr, awlen, awvalid, wdata, wlast, wvalid, bready, araddr, arlen, arvalid,
               rready,
        output awready, wready, bvalid, arready, rvalid, rdata
    );

    modport master (
        output awaddr, awlen, awvalid, wdata, wlast, wvalid, bready, araddr, arlen, arvalid,
               rready,
        input  awready, wready, bvalid, arready, rvalid, rdata
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI burst slave backed by a single-port word SRAM; serves one transaction at a time.
// Define AXI_SRAM_LATENCY_EN to add READ_LATENCY wait cycles before first read beat and bvalid.
module axi_sram_slave #(
    parameter int unsigned MEM_WORDS      = 4096,
    parameter int unsigned MEM_ADDR_WIDTH = $clog2(MEM_WORDS),
    parameter int unsigned READ_LATENCY   = 4
) (
    input  logic      clk,
    input  logic      reset,
    axi_sram_if.slave axi,
    output logic      protocol_error
);

    typedef enum logic [2:0] {
        StIdle,
        StWriteData,
        StWriteResp,
        StReadFetch,
        StReadData
    } state_e;

    state_e                    state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] idx_q, idx_d, mem_addr;
    logic [7:0]                len_q, len_d, cnt_q, cnt_d;
    logic [31:0]               rdata_q;
    logic                      perr_q, perr_d;
    logic                      mem_we, mem_re;
    logic                      last_beat;
    logic                      lat_done;
    logic [31:0]               mem [MEM_WORDS];

`ifdef AXI_SRAM_LATENCY_EN
    logic [15:0] lat_q, lat_d;
    assign lat_done = (lat_q == '0);
`else
    logic unused_read_latency;
    assign unused_read_latency = ^READ_LATENCY;
    assign lat_done = 1'b1;
`endif

    assign last_beat      = (cnt_q == len_q);
    assign axi.rdata      = rdata_q;
    assign protocol_error = perr_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        perr_d      = perr_q;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_addr    = idx_q;
        axi.awready = 1'b0;
        axi.arready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.rvalid  = 1'b0;
`ifdef AXI_SRAM_LATENCY_EN
        lat_d       = lat_q;
`endif
        unique case (state_q)
            StIdle: begin
                axi.awready = 1'b1;
                // Writes take priority; a concurrent read waits until the write response retires.
                axi.arready = !axi.awvalid;
                if (axi.awvalid) begin
                    idx_d   = axi.awaddr[MEM_ADDR_WIDTH+1:2];
                    len_d   = axi.awlen;
                    cnt_d   = '0;
                    state_d = StWriteData;
                end else if (axi.arvalid) begin
                    idx_d   = axi.araddr[MEM_ADDR_WIDTH+1:2];
                    len_d   = axi.arlen;
                    cnt_d   = '0;
                    state_d = StReadFetch;
`ifdef AXI_SRAM_LATENCY_EN
                    lat_d   = 16'(READ_LATENCY);
`endif
                end
            end
            StWriteData: begin
                axi.wready = 1'b1;
                if (axi.wvalid) begin
                    mem_we = 1'b1;
                    idx_d  = idx_q + 1'b1;
                    cnt_d  = cnt_q + 8'd1;
                    // The burst length is authoritative; a misplaced wlast is only flagged.
                    if (axi.wlast != last_beat) perr_d = 1'b1;
                    if (last_beat) begin
                        state_d = StWriteResp;
`ifdef AXI_SRAM_LATENCY_EN
                        lat_d   = 16'(READ_LATENCY);
`endif
                    end
                end
            end
            StWriteResp: begin
                axi.bvalid = lat_done;
`ifdef AXI_SRAM_LATENCY_EN
                if (!lat_done) lat_d = lat_q - 16'd1;
`endif
                if (lat_done && axi.bready) state_d = StIdle;
            end
            StReadFetch: begin
                if (lat_done) begin
                    mem_re  = 1'b1;
                    state_d = StReadData;
                end
`ifdef AXI_SRAM_LATENCY_EN
                else begin
                    lat_d = lat_q - 16'd1;
                end
`endif
            end
            StReadData: begin
                axi.rvalid = 1'b1;
                if (axi.rready) begin
                    if (last_beat) begin
                        state_d = StIdle;
                    end else begin
                        // Prefetch the next word on the accepting edge to sustain one beat/cycle.
                        idx_d    = idx_q + 1'b1;
                        cnt_d    = cnt_q + 8'd1;
                        mem_addr = idx_q + 1'b1;
                        mem_re   = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            perr_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            perr_q  <= perr_d;
            if (mem_re) rdata_q <= mem[mem_addr];
        end
    end

`ifdef AXI_SRAM_LATENCY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lat_q <= '0;
        else       lat_q <= lat_d;
    end
`endif

    // Storage array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= axi.wdata;
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: burst table plus hand-written ordering/error/reset sequences.
module tb_axi_sram_slave;

    logic clk = 1'b0;
    logic reset;
    logic protocol_error;
    int   n_checks = 0;
    int   n_pass   = 0;

    axi_sram_if axi ();

    axi_sram_slave #(
        .MEM_WORDS      (4096),
        .MEM_ADDR_WIDTH (12),
        .READ_LATENCY   (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .axi            (axi),
        .protocol_error (protocol_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [31:0] d0;
        bit          toggle;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    // wlast_beat < 0 places wlast correctly on the final beat.
    task automatic write_burst(input logic [31:0] addr, input logic [7:0] len,
                               input logic [31:0] d0, input int wlast_beat, input string tag);
        int g;
        @(negedge clk);
        axi.awaddr  = addr;
        axi.awlen   = len;
        axi.awvalid = 1'b1;
        #1;
        g = 0;
        while (!axi.awready && g < 50) begin @(negedge clk); #1; g++; end
        if (g == 50) begin
            check_bit($sformatf("%s aw timeout", tag), 1'b0, 1'b1);
            axi.awvalid = 1'b0;
            return;
        end
        @(negedge clk);
        axi.awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            axi.wdata  = d0 + i;
            axi.wlast  = (wlast_beat < 0) ? (i == int'(len)) : (i == wlast_beat);
            axi.wvalid = 1'b1;
            #1;
            g = 0;
            while (!axi.wready && g < 50) begin @(negedge clk); #1; g++; end
            if (g == 50) begin
                check_bit($sformatf("%s w timeout", tag), 1'b0, 1'b1);
                axi.wvalid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        axi.wvalid = 1'b0;
        axi.wlast  = 1'b0;
        check_bit($sformatf("%s bvalid after last beat", tag), axi.bvalid, 1'b1);
        axi.bready = 1'b1;
        @(negedge clk);
        axi.bready = 1'b0;
        check_bit($sformatf("%s bvalid drops", tag), axi.bvalid, 1'b0);
    endtask

    // abort_at >= 0 asserts reset when that beat is presented and leaves reset high.
    task automatic read_burst(input logic [31:0] addr, input logic [7:0] len,
                              input logic [31:0] d0, input bit toggle, input int abort_at,
                              input string tag);
        int g;
        int beat;
        int cyc;
        @(negedge clk);
        axi.araddr  = addr;
        axi.arlen   = len;
        axi.arvalid = 1'b1;
        axi.rready  = 1'b0;
        #1;
        g = 0;
        while (!axi.arready && g < 50) begin @(negedge clk); #1; g++; end
        if (g == 50) begin
            check_bit($sformatf("%s ar timeout", tag), 1'b0, 1'b1);
            axi.arvalid = 1'b0;
            return;
        end
        @(negedge clk);
        axi.arvalid = 1'b0;
        check_bit($sformatf("%s rvalid low during fetch", tag), axi.rvalid, 1'b0);
        @(negedge clk);
        check_bit($sformatf("%s rvalid 2 cycles after ar", tag), axi.rvalid, 1'b1);
        beat = 0;
        cyc  = 0;
        while (beat <= int'(len) && cyc < 2000) begin
            if (beat == abort_at) begin
                reset = 1'b1;
                axi.rready = 1'b0;
                #1;
                check_bit($sformatf("%s rvalid on reset", tag), axi.rvalid, 1'b0);
                return;
            end
            axi.rready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            check_bit($sformatf("%s rvalid beat %0d", tag, beat), axi.rvalid, 1'b1);
            check($sformatf("%s rdata beat %0d", tag, beat), axi.rdata, d0 + beat);
            if (axi.rvalid && axi.rready) beat++;
            cyc++;
            @(negedge clk);
        end
        axi.rready = 1'b0;
        if (cyc >= 2000) check_bit($sformatf("%s r timeout", tag), 1'b0, 1'b1);
        #1;
        check_bit($sformatf("%s rvalid drops after last", tag), axi.rvalid, 1'b0);
        check_bit($sformatf("%s arready back", tag), axi.arready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // is_wr, addr, len, first data word (written, or expected on read), toggled rready
        vecs[0] = '{1'b1, 32'h0000_0040, 8'd15, 32'h0000_1000, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_0040, 8'd15, 32'h0000_1000, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_0040, 8'd15, 32'h0000_1000, 1'b1};
        vecs[3] = '{1'b1, 32'h0000_3FF8, 8'd3,  32'h0000_00A0, 1'b0};
        vecs[4] = '{1'b0, 32'h0000_0000, 8'd1,  32'h0000_00A2, 1'b0};
        vecs[5] = '{1'b0, 32'h0000_7FF8, 8'd3,  32'h0000_00A0, 1'b1};
        vecs[6] = '{1'b1, 32'h0000_0100, 8'd0,  32'hDEAD_0000, 1'b0};

        reset       = 1'b1;
        axi.awaddr  = '0;
        axi.awlen   = '0;
        axi.awvalid = 1'b0;
        axi.wdata   = '0;
        axi.wlast   = 1'b0;
        axi.wvalid  = 1'b0;
        axi.bready  = 1'b0;
        axi.araddr  = '0;
        axi.arlen   = '0;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;
        repeat (3) @(negedge clk);
        check_bit("reset bvalid", axi.bvalid, 1'b0);
        check_bit("reset rvalid", axi.rvalid, 1'b0);
        check_bit("reset wready", axi.wready, 1'b0);
        check("reset rdata", axi.rdata, 32'h0);
        check_bit("reset protocol_error", protocol_error, 1'b0);
        reset = 1'b0;
        #1;
        check_bit("idle awready", axi.awready, 1'b1);
        check_bit("idle arready", axi.arready, 1'b1);

        for (int v = 0; v < 7; v++) begin
            if (vecs[v].is_wr) begin
                write_burst(vecs[v].addr, vecs[v].len, vecs[v].d0, -1, $sformatf("vec%0d", v));
                check_bit($sformatf("vec%0d protocol_error", v), protocol_error, 1'b0);
            end else begin
                read_burst(vecs[v].addr, vecs[v].len, vecs[v].d0, vecs[v].toggle, -1,
                           $sformatf("vec%0d", v));
            end
        end
        // Low address bits ignored: 0x103 is the same word as 0x100.
        read_burst(32'h0000_0103, 8'd0, 32'hDEAD_0000, 1'b0, -1, "lowbits");

        // Simultaneous aw/ar to 0x80: write served first, read then sees new data.
        @(negedge clk);
        axi.awaddr  = 32'h80;
        axi.awlen   = 8'd0;
        axi.awvalid = 1'b1;
        axi.araddr  = 32'h80;
        axi.arlen   = 8'd0;
        axi.arvalid = 1'b1;
        #1;
        check_bit("race awready", axi.awready, 1'b1);
        check_bit("race arready blocked", axi.arready, 1'b0);
        @(negedge clk);
        axi.awvalid = 1'b0;
        axi.wdata   = 32'h55AA_1234;
        axi.wlast   = 1'b1;
        axi.wvalid  = 1'b1;
        #1;
        check_bit("race arready during write", axi.arready, 1'b0);
        @(negedge clk);
        axi.wvalid = 1'b0;
        axi.wlast  = 1'b0;
        check_bit("race bvalid", axi.bvalid, 1'b1);
        check_bit("race arready during resp", axi.arready, 1'b0);
        axi.bready = 1'b1;
        @(negedge clk);
        axi.bready = 1'b0;
        #1;
        check_bit("race arready after resp", axi.arready, 1'b1);
        @(negedge clk);
        axi.arvalid = 1'b0;
        check_bit("race rvalid fetch", axi.rvalid, 1'b0);
        @(negedge clk);
        check_bit("race rvalid", axi.rvalid, 1'b1);
        check("race rdata new", axi.rdata, 32'h55AA_1234);
        axi.rready = 1'b1;
        @(negedge clk);
        axi.rready = 1'b0;
        check_bit("race rvalid drops", axi.rvalid, 1'b0);

        // Misplaced wlast: flagged and sticky, burst still runs 4 beats.
        write_burst(32'h200, 8'd3, 32'h77, 1, "badlast");
        check_bit("badlast protocol_error", protocol_error, 1'b1);
        write_burst(32'h300, 8'd0, 32'h1, -1, "goodafter");
        check_bit("protocol_error sticky", protocol_error, 1'b1);
        read_burst(32'h200, 8'd3, 32'h77, 1'b0, -1, "badlast rd");
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_bit("reset clears protocol_error", protocol_error, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Reset mid-read at beat 5, then a fresh burst must work.
        read_burst(32'h40, 8'd15, 32'h1000, 1'b0, 5, "abort");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_bit("post-abort awready", axi.awready, 1'b1);
        check_bit("post-abort rvalid", axi.rvalid, 1'b0);
        write_burst(32'h500, 8'd1, 32'hBEEF_0000, -1, "post-abort wr");
        read_burst(32'h500, 8'd1, 32'hBEEF_0000, 1'b0, -1, "post-abort rd");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI burst slave that sits directly downstream of the L2 system memory interface.
- Accepts its write-address, write-data, write-response, read-address and read-data channels and backs them with a synchronous single-port word SRAM.
- Used as on-chip system memory in FPGA builds and as the memory model for L2 simulation.
- Serves one transaction at a time and preserves write-before-read ordering as issued.

Parameters:
- MEM_WORDS, 4096, depth of backing SRAM in 32-bit words; power of two.
- MEM_ADDR_WIDTH, $clog2(MEM_WORDS), word index width.
- READ_LATENCY, 4, extra wait cycles before the first read beat; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- axi_awaddr  in  32  write burst byte address
- axi_awlen  in  8  write beats minus one
- axi_awvalid  in  1  write address valid
- axi_awready  out  1  write address accepted
- axi_wdata  in  32  write beat data
- axi_wlast  in  1  final write beat marker
- axi_wvalid  in  1  write data valid
- axi_wready  out  1  write data accepted
- axi_bvalid  out  1  write response valid
- axi_bready  in  1  write response accepted
- axi_araddr  in  32  read burst byte address
- axi_arlen  in  8  read beats minus one
- axi_arvalid  in  1  read address valid
- axi_arready  out  1  read address accepted
- axi_rvalid  out  1  read beat valid
- axi_rready  in  1  read beat accepted
- axi_rdata  out  32  read beat data
- protocol_error  out  1  sticky: wlast disagrees with the beat count

Behaviour:
- Reset is asynchronous and active-high. While asserted: state=IDLE, bvalid=0, rvalid=0, wready=0, rdata=0, protocol_error=0, counters=0. SRAM contents are not reset.
- States are IDLE, WRITE_DATA, WRITE_RESP, READ_FETCH, READ_DATA.
- IDLE:
  - awready=1. arready=!awvalid, so writes win when both are valid.
  - An aw handshake latches word index awaddr[MEM_ADDR_WIDTH+1:2] and awlen, beat count=0, then goes to WRITE_DATA.
  - Otherwise an ar handshake latches araddr the same way, then goes to READ_FETCH.
  - awaddr[1:0]/araddr[1:0] are ignored. Upper address bits beyond the SRAM are ignored, so addresses alias modulo MEM_WORDS.
- WRITE_DATA:
  - wready=1.
  - Each wvalid beat writes wdata to mem[index], increments index (wraps modulo MEM_WORDS) and increments count.
  - On the beat where count==len, go to WRITE_RESP.
  - If wlast != (count==len) on any accepted beat, set protocol_error. The burst still ends on the count, not on wlast.
- WRITE_RESP:
  - bvalid=1, held until bready.
  - On bready, return to IDLE. bvalid drops the next cycle.
- READ_FETCH:
  - Issue an SRAM read of mem[index]. Data lands in the rdata register next cycle; go to READ_DATA.
  - First-beat latency from the ar handshake is 2 cycles (rvalid asserts 2 cycles after the arready cycle).
- READ_DATA:
  - rvalid=1; rdata is stable while rready=0.
  - On rvalid&&rready with count<len: index+1, count+1, and an SRAM read of the new index loads rdata in the same edge. Sustains 1 beat/cycle.
  - On the beat with count==len, return to IDLE; rvalid=0 the next cycle.
- No rlast/rresp/bresp ports; responses are always OKAY.
- Simultaneous awvalid and arvalid in IDLE: the write is served first. The read stays pending until the write response completes.
- A write to address X followed by a read of X returns the new data.
- Reset asserted mid-burst aborts immediately. Partially written words remain in the SRAM.
- len=0 means a single beat. len=255 means 256 beats and wraps the index if needed.

Optional Feature:
- Macro: AXI_SRAM_LATENCY_EN.
- Defined: READ_FETCH holds for READ_LATENCY extra cycles (down-counter) before the SRAM read. First-beat latency becomes 2+READ_LATENCY. Also, bvalid is delayed by READ_LATENCY cycles after the last write beat. Used to stress SMI wait paths.
- Undefined: counters are absent and the latencies are exactly as in Behaviour.

Test Plan:
- Write burst awaddr=0x40, awlen=15, data 0x1000..0x100F, wlast on beat 15 → mem[16..31]=0x1000..0x100F; bvalid one cycle after last beat; protocol_error=0.
- Read burst araddr=0x40, arlen=15, rready=1 → rvalid 2 cycles after arready; 16 consecutive beats 0x1000..0x100F; then arready high again.
- Read with rready toggling 1,0,0,1 per cycle → no dropped or duplicated beats; rdata held stable while rready=0.
- awvalid and arvalid asserted in the same cycle to the same address 0x80 → write completes with bvalid/bready before arready; read returns the new data.
- Write awlen=3 with wlast asserted on beat 1 → protocol_error=1 and sticky; burst still consumes 4 beats; reset clears the flag.
- Reset asserted mid-read at beat 5 → rvalid=0 immediately; after release the slave is in IDLE with awready=1 and accepts a new burst.
